// File: rtl/imm_encoder.sv
// Two-stage ld/addi/sd/beq instruction encoder with valid/ready on both sides.
// S1 latches the request and its range check; S2 holds the packed word.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [63:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0]  OP_LD = 2'd0, OP_ADDI = 2'd1, OP_SD = 2'd2, OP_BEQ = 2'd3;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic        legal;
  } s1_t;

  s1_t         s1_d, s1_q;
  logic [1:0]  vld_pipe_q;   // [0]=S1 valid, [1]=S2 valid (out_valid)
  logic [31:0] instr_d, instr_q;
  logic        err_q;
  logic [CNT_W-1:0] enc_cnt_q, err_cnt_q;
  logic        adv, hs_out, hi11_same, hi12_same;

  assign out_valid = vld_pipe_q[1];
  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign hs_out    = out_valid & out_ready;

  // Sign-extension check: all upper bits equal the sign bit of the field
  assign hi11_same = (&in_imm[63:11]) | ~(|in_imm[63:11]);
  assign hi12_same = (&in_imm[63:12]) | ~(|in_imm[63:12]);

  always_comb begin
    s1_d.op    = in_op;
    s1_d.rd    = in_rd;
    s1_d.rs1   = in_rs1;
    s1_d.rs2   = in_rs2;
    s1_d.imm   = in_imm[12:0];
    s1_d.legal = (in_op == OP_BEQ) ? (hi12_same & ~in_imm[0]) : hi11_same;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
    end else if (adv) begin
      vld_pipe_q <= {vld_pipe_q[0], in_valid};
      s1_q       <= s1_d;
    end
  end

  always_comb begin
    instr_d = NOP;
    if (s1_q.legal) begin
      unique case (s1_q.op)
        OP_LD:   instr_d = {s1_q.imm[11:0], s1_q.rs1, 3'b011, s1_q.rd, 7'b0000011};
        OP_ADDI: instr_d = {s1_q.imm[11:0], s1_q.rs1, 3'b000, s1_q.rd, 7'b0010011};
        OP_SD:   instr_d = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, 3'b011,
                            s1_q.imm[4:0], 7'b0100011};
        OP_BEQ:  instr_d = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, 3'b000,
                            s1_q.imm[4:1], s1_q.imm[11], 7'b1100011};
        default: instr_d = NOP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      err_q   <= 1'b0;
    end else if (adv) begin
      instr_q <= instr_d;
      err_q   <= ~s1_q.legal;
    end
  end

  assign out_instr = instr_q;
  assign out_err   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (hs_out) begin
      if (enc_cnt_q != {CNT_W{1'b1}})          enc_cnt_q <= enc_cnt_q + 1'b1;
      if (err_q && err_cnt_q != {CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign enc_cnt = enc_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized + directed bench for imm_encoder against an arithmetic encode/decode model.
module tb_imm_encoder;
  logic        clk = 0, reset = 1;
  logic        in_valid = 0, out_ready = 0;
  logic [1:0]  in_op = 0;
  logic [4:0]  in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [63:0] in_imm = 0;
  logic        in_ready, out_valid, out_err, in_ready2, out_valid2, out_err2;
  logic [31:0] out_instr, out_instr2;
  logic [15:0] enc_cnt, err_cnt;
  logic [1:0]  enc_cnt2, err_cnt2;

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .enc_cnt(enc_cnt), .err_cnt(err_cnt));

  imm_encoder #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_err(out_err2), .enc_cnt(enc_cnt2), .err_cnt(err_cnt2));

  typedef struct {
    logic [31:0] instr;
    logic        err;
    longint      imm;
  } exp_t;

  exp_t   sb_q[$];
  int     n_vec = 0, n_miss = 0;
  longint exp_enc = 0, exp_err = 0;
  bit     acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder from the format tables, using plain arithmetic
  function automatic exp_t model(input int op, input int rd, input int rs1, input int rs2,
                                 input longint imm);
    exp_t e;
    longint u;
    longint w;
    int opc, f3;
    bit legal;
    case (op)
      0: begin opc = 'b0000011; f3 = 3; end
      1: begin opc = 'b0010011; f3 = 0; end
      2: begin opc = 'b0100011; f3 = 3; end
      default: begin opc = 'b1100011; f3 = 0; end
    endcase
    if (op == 3) legal = (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
    else         legal = (imm >= -2048) && (imm <= 2047);
    u = imm & 'h1FFF;
    case (op)
      0, 1: w = ((u & 'hFFF) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + opc;
      2:    w = (((u & 'hFFF) >> 5) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
                + ((u & 31) << 7) + opc;
      default: w = (((u >> 12) & 1) << 31) + (((u >> 5) & 63) << 25) + (rs2 << 20)
                + (rs1 << 15) + (f3 << 12) + (((u >> 1) & 15) << 8)
                + (((u >> 11) & 1) << 7) + opc;
    endcase
    e.instr = legal ? w[31:0] : 32'h13;
    e.err   = !legal;
    e.imm   = imm;
    return e;
  endfunction

  // Datapath immediate generator, used to confirm round-trip recovery
  function automatic longint immgen(input logic [31:0] w);
    logic [31:0] t;
    longint v;
    t = w;
    case (t[6:0])
      7'b0100011: v = ((t >> 25) << 5) + ((t >> 7) & 31);
      7'b1100011: v = (((t >> 31) & 1) << 12) + (((t >> 7) & 1) << 11)
                      + (((t >> 25) & 63) << 5) + (((t >> 8) & 15) << 1);
      default:    v = t >> 20;
    endcase
    if (t[6:0] == 7'b1100011) begin if (v >= 4096) v = v - 8192; end
    else if (v >= 2048) v = v - 4096;
    return v;
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    chk("in_ready", in_ready, !out_valid | out_ready);
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("instr", out_instr, e.instr);
        chk("err", out_err, e.err);
        if (!e.err) chk("immgen", immgen(out_instr), e.imm);
        exp_enc++;
        if (e.err) exp_err++;
      end
    end
    acc = in_valid && in_ready;
    if (acc) sb_q.push_back(model(in_op, in_rd, in_rs1, in_rs2, longint'(in_imm)));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input int rd, input int rs1, input int rs2,
                       input longint imm);
    in_op = op[1:0]; in_rd = rd[4:0]; in_rs1 = rs1[4:0]; in_rs2 = rs2[4:0];
    in_imm = imm;
  endtask

  // Single request on an empty pipe: check latency and the spec's literal word
  task automatic send_dir(input string tag, input int op, input int rd, input int rs1,
                          input int rs2, input longint imm, input logic [31:0] w,
                          input logic err);
    drive(op, rd, rs1, rs2, imm);
    in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
    chk({tag, "_lat1"}, out_valid, 0);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_word"}, out_instr, w);
    chk({tag, "_oerr"}, out_err, err);
    tick();
  endtask

  initial begin
    logic [31:0] held;
    int sent;
    longint edges[10];
    edges = '{-2048, 2047, 2048, -2049, 4094, 4095, -4096, -4097, 0, -1};
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_err", out_err, 0);
    chk("rst_enc", enc_cnt, 0);
    chk("rst_errc", err_cnt, 0);
    #10 reset = 0;
    @(posedge clk); #1;

    send_dir("ld", 0, 5, 2, 0, 8, 32'h00813283, 0);
    chk("ld_enc", enc_cnt, 1);
    send_dir("sd", 2, 0, 2, 6, -8, 32'hFE613C23, 0);
    send_dir("beq", 3, 0, 1, 2, 16, 32'h00208863, 0);
    send_dir("addi_big", 1, 1, 1, 0, 2048, 32'h00000013, 1);
    send_dir("beq_odd", 3, 0, 1, 2, 3, 32'h00000013, 1);
    send_dir("addi_min", 1, 0, 0, 0, -2048, 32'h80000013, 0);
    chk("err_cnt2", err_cnt, 2);
    chk("enc_cnt6", enc_cnt, 6);
    chk("sat_enc", enc_cnt2, 3);

    // 8-deep stream with a 3-cycle consumer stall in the middle
    sent = 0;
    held = 0;
    for (int cyc = 0; sent < 8 && cyc < 100; cyc++) begin
      drive(sent % 4, sent + 1, sent + 3, sent + 7, (sent * 8) - 24);
      in_valid = 1;
      out_ready = !(cyc >= 4 && cyc <= 6);
      #1;
      if (cyc == 4) held = out_instr;
      if (cyc >= 4 && cyc <= 6) begin
        chk("stall_rdy", in_ready, 0);
        chk("stall_hold", out_instr, held);
      end
      tick();
      if (acc) sent++;
    end
    chk("stream_sent", sent, 8);
    in_valid = 0; out_ready = 1;
    repeat (3) tick();
    chk("stream_drain", sb_q.size(), 0);
    chk("stream_enc", enc_cnt, 14);

    // Reset with two requests in flight
    drive(1, 3, 4, 0, 100); in_valid = 1; tick();
    drive(2, 0, 4, 5, -100); tick();
    in_valid = 0;
    reset = 1; #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_enc", enc_cnt, 0);
    chk("mrst_errc", err_cnt, 0);
    sb_q.delete(); exp_enc = 0; exp_err = 0;
    #2 reset = 0;
    send_dir("post_rst", 1, 7, 8, 0, -5, 32'hFFB40393, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      longint imm;
      case ($urandom_range(0, 3))
        0: imm = longint'($urandom_range(0, 8191)) - 4096;
        1: imm = edges[$urandom_range(0, 9)];
        2: imm = {$urandom, $urandom};
        default: imm = longint'($urandom_range(0, 31)) - 16;
      endcase
      drive($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), imm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 0; out_ready = 1;
    repeat (4) tick();
    chk("final_drain", sb_q.size(), 0);
    chk("final_enc", enc_cnt, exp_enc);
    chk("final_errc", err_cnt, exp_err);
    chk("final_sat", enc_cnt2, (exp_enc > 3) ? 3 : exp_enc);
    chk("final_sat_err", err_cnt2, (exp_err > 3) ? 3 : exp_err);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
